series_adder_frame_loader: RTL and testbench

- Upstream feeder for series_adder_data_streamer.
- Accepts 32-bit operand words one per handshake and packs M words into one M*32-bit frame.
- Presents the frame on a valid/ready interface that connects directly to the streamer's data_vld/data_i/data_rdy.
- Ping-pong double buffer, so the next frame loads while the streamer is busy with the current one.

---
 rtl/series_adder_frame_loader.sv | 104 ++++++++++
 tb/tb_series_adder_frame_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/series_adder_frame_loader.sv
// Packs M 32-bit operand words into M*32-bit frames through a ping-pong double buffer.
// Optional short-frame close with zero padding: define FRAME_ZERO_PAD_EN.
module series_adder_frame_loader #(
    parameter int unsigned M = 32
) (
    input  logic            clk,
    input  logic            rst_p,
    input  logic [31:0]     s_data_i,
    input  logic            s_vld_i,
    input  logic            s_last_i,
    output logic            s_rdy_o,
    output logic [M*32-1:0] frame_o,
    output logic            frame_vld_o,
    input  logic            frame_rdy_i,
    output logic [15:0]     frame_cnt_o,
    output logic [1:0]      fill_o
);

    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LastSlot = CW'(M - 1);

    logic [M*32-1:0] bufs_q [2];
    logic [1:0]      full_q, full_d;
    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [CW-1:0]   word_ctr_q, word_ctr_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            accept, close, xfer;

`ifdef FRAME_ZERO_PAD_EN
    assign close = accept && ((word_ctr_q == LastSlot) || s_last_i);
`else
    logic unused_last;
    assign unused_last = s_last_i;
    assign close = accept && (word_ctr_q == LastSlot);
`endif

    assign accept = s_vld_i && !full_q[wr_sel_q];
    assign xfer   = full_q[rd_sel_q] && frame_rdy_i;

    // Close and transfer always hit different buffers, so both may apply in one cycle.
    always_comb begin
        full_d      = full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        word_ctr_d  = word_ctr_q;
        frame_cnt_d = frame_cnt_q;
        if (close) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
            word_ctr_d       = '0;
        end else if (accept) begin
            word_ctr_d = word_ctr_q + CW'(1);
        end
        if (xfer) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
            frame_cnt_d      = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            full_q      <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            word_ctr_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            word_ctr_q  <= word_ctr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
`ifdef FRAME_ZERO_PAD_EN
        if (rst_p) begin
            bufs_q[0] <= '0;
            bufs_q[1] <= '0;
        end else begin
            if (xfer) begin
                bufs_q[rd_sel_q] <= '0;
            end
            if (accept) begin
                bufs_q[wr_sel_q][{word_ctr_q, 5'd0} +: 32] <= s_data_i;
            end
        end
`else
        if (accept) begin
            bufs_q[wr_sel_q][{word_ctr_q, 5'd0} +: 32] <= s_data_i;
        end
`endif
    end

    assign s_rdy_o     = !full_q[wr_sel_q];
    assign frame_o     = bufs_q[rd_sel_q];
    assign frame_vld_o = full_q[rd_sel_q];
    assign frame_cnt_o = frame_cnt_q;
    assign fill_o      = {1'b0, full_q[0]} + {1'b0, full_q[1]};

endmodule

// File: tb/tb_series_adder_frame_loader.sv
// Directed bench for series_adder_frame_loader: an M=4 instance plus an M=1 instance.
module tb_series_adder_frame_loader;

    logic         clk = 1'b0;
    logic         rst_p;
    logic [31:0]  s_data;
    logic         s_vld, s_last, s_rdy;
    logic [127:0] frame;
    logic         frame_vld, frame_rdy;
    logic [15:0]  frame_cnt;
    logic [1:0]   fill;

    logic [31:0]  s1_data;
    logic         s1_vld, s1_rdy;
    logic [31:0]  frame1;
    logic         frame1_vld, frame1_rdy;
    logic [15:0]  frame1_cnt;
    logic [1:0]   fill1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    series_adder_frame_loader #(.M(4)) dut (
        .clk(clk), .rst_p(rst_p), .s_data_i(s_data), .s_vld_i(s_vld), .s_last_i(s_last),
        .s_rdy_o(s_rdy), .frame_o(frame), .frame_vld_o(frame_vld), .frame_rdy_i(frame_rdy),
        .frame_cnt_o(frame_cnt), .fill_o(fill)
    );

    series_adder_frame_loader #(.M(1)) dut1 (
        .clk(clk), .rst_p(rst_p), .s_data_i(s1_data), .s_vld_i(s1_vld), .s_last_i(1'b0),
        .s_rdy_o(s1_rdy), .frame_o(frame1), .frame_vld_o(frame1_vld), .frame_rdy_i(frame1_rdy),
        .frame_cnt_o(frame1_cnt), .fill_o(fill1)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        s_data = d;
        s_last = last;
        s_vld  = 1'b1;
        while (!s_rdy && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("send_timeout", 128'd0, 128'd1);
        tick();
        s_vld  = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
    endtask

    initial begin
        rst_p = 1'b0; s_data = '0; s_vld = 1'b0; s_last = 1'b0; frame_rdy = 1'b0;
        s1_data = '0; s1_vld = 1'b0; frame1_rdy = 1'b0;
        #2;
        do_reset();
        check("rst_rdy", 128'(s_rdy), 128'd1);
        check("rst_vld", 128'(frame_vld), 128'd0);
        check("rst_fill", 128'(fill), 128'd0);
        check("rst_cnt", 128'(frame_cnt), 128'd0);

        // Basic fill with consumer always ready
        frame_rdy = 1'b1;
        send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0);
        check("fill_novld", 128'(frame_vld), 128'd0);
        send(32'h44, 1'b0);
        check("fill_vld", 128'(frame_vld), 128'd1);
        check("fill_frame", frame, pack4(32'h11, 32'h22, 32'h33, 32'h44));
        check("fill_fill", 128'(fill), 128'd1);
        tick();
        check("fill_vld_once", 128'(frame_vld), 128'd0);
        check("fill_cnt", 128'(frame_cnt), 128'd1);
        check("fill_fill0", 128'(fill), 128'd0);

        // Backpressure: two frames buffered, then drain one at a time
        do_reset();
        frame_rdy = 1'b0;
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        check("bp_rdy_low", 128'(s_rdy), 128'd0);
        check("bp_fill2", 128'(fill), 128'd2);
        check("bp_frame1", frame, pack4(32'd1, 32'd2, 32'd3, 32'd4));
        s_data = 32'd9; s_vld = 1'b1;
        tick(); tick();
        check("bp_stall", 128'(s_rdy), 128'd0);
        frame_rdy = 1'b1;
        tick();
        frame_rdy = 1'b0;
        check("bp_rdy_back", 128'(s_rdy), 128'd1);
        check("bp_cnt1", 128'(frame_cnt), 128'd1);
        check("bp_frame2", frame, pack4(32'd5, 32'd6, 32'd7, 32'd8));
        s_vld = 1'b0;
        for (int i = 9; i <= 12; i++) send(32'(i), 1'b0);
        check("bp_fill2b", 128'(fill), 128'd2);
        check("bp_frame2_hold", frame, pack4(32'd5, 32'd6, 32'd7, 32'd8));
        frame_rdy = 1'b1;
        tick();
        check("bp_frame3", frame, pack4(32'd9, 32'd10, 32'd11, 32'd12));
        check("bp_vld3", 128'(frame_vld), 128'd1);
        tick();
        frame_rdy = 1'b0;
        check("bp_cnt3", 128'(frame_cnt), 128'd3);
        check("bp_empty", 128'(frame_vld), 128'd0);

        // Close into one buffer while the other transfers
        do_reset();
        for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) send(32'h200 + 32'(i), 1'b0);
        check("ov_fill1", 128'(fill), 128'd1);
        s_data = 32'h203; s_vld = 1'b1; frame_rdy = 1'b1;
        tick();
        s_vld = 1'b0; frame_rdy = 1'b0;
        check("ov_fill", 128'(fill), 128'd1);
        check("ov_cnt", 128'(frame_cnt), 128'd1);
        check("ov_frame", frame, pack4(32'h200, 32'h201, 32'h202, 32'h203));

        // Reset mid-frame discards the partial frame
        do_reset();
        send(32'h1, 1'b0); send(32'h2, 1'b0);
        do_reset();
        check("mr_rdy", 128'(s_rdy), 128'd1);
        check("mr_vld", 128'(frame_vld), 128'd0);
        check("mr_fill", 128'(fill), 128'd0);
        check("mr_cnt", 128'(frame_cnt), 128'd0);
        send(32'hA, 1'b0); send(32'hB, 1'b0); send(32'hC, 1'b0); send(32'hD, 1'b0);
        check("mr_frame", frame, pack4(32'hA, 32'hB, 32'hC, 32'hD));

        // Short frame via s_last_i
        do_reset();
        send(32'h5, 1'b0); send(32'h6, 1'b1);
`ifdef FRAME_ZERO_PAD_EN
        check("zp_vld", 128'(frame_vld), 128'd1);
        check("zp_frame", frame, pack4(32'h5, 32'h6, 32'h0, 32'h0));
`else
        check("nl_vld", 128'(frame_vld), 128'd0);
        send(32'h7, 1'b0); send(32'h8, 1'b0);
        check("nl_vld2", 128'(frame_vld), 128'd1);
        check("nl_frame", frame, pack4(32'h5, 32'h6, 32'h7, 32'h8));
`endif

        // M=1: every accepted word is a frame
        s1_data = 32'h99; s1_vld = 1'b1;
        tick();
        s1_vld = 1'b0;
        check("m1_vld", 128'(frame1_vld), 128'd1);
        check("m1_frame", 128'(frame1), 128'h99);
        frame1_rdy = 1'b1;
        tick();
        check("m1_cnt", 128'(frame1_cnt), 128'd1);
        check("m1_empty", 128'(fill1), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
